// File: rtl/stopwatch_pkg.sv
// Shared encodings and limits for the lap stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } sw_state_t;

    localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/lap_fifo.sv
// First-word-fall-through buffer holding captured lap times.
module lap_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign valid = (count != '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A full buffer still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    assign rd_data = valid ? mem[rd_ptr] : '0;

    // NOTE: storage carries no reset; count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Minutes/seconds stopwatch with start/stop/clear and an optional lap buffer
// compiled in only when LAP_CAPTURE_EN is defined.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int MIN_W     = 8,
    parameter int LAP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           clear,
    input  logic                           lap,
    input  logic                           lap_rd,
    output logic [MIN_W-1:0]               minutes,
    output logic [5:0]                     seconds,
    output logic [1:0]                     status,
    output logic                           overflow,
    output logic [MIN_W-1:0]               lap_minutes,
    output logic [5:0]                     lap_seconds,
    output logic                           lap_valid,
    output logic                           lap_full,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count
);

    localparam int               DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_MAX  = '1;

    sw_state_t        state;
    sw_state_t        state_nxt;
    logic [DIV_W-1:0] div;
    logic             running;
    logic             tick;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Priority clear > stop > start; a stop that cannot apply still masks start.
    // NOTE: state_nxt defaults to state before any branch so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else if (stop) begin
            if (state == ST_RUNNING) state_nxt = ST_PAUSED;
        end else if (start && state != ST_RUNNING) begin
            state_nxt = ST_RUNNING;
        end
    end

    always_comb begin
        status  = state;
        running = (state == ST_RUNNING);
    end

    // Counting follows the registered state, so the edge sampling stop still counts
    // and the edge sampling start does not.
    assign tick = running && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div      <= '0;
            seconds  <= '0;
            minutes  <= '0;
            overflow <= 1'b0;
        end else if (running) begin
            div <= tick ? '0 : div + DIV_W'(1);
            if (tick) begin
                if (seconds == SEC_MAX) begin
                    seconds <= '0;
                    minutes <= minutes + MIN_W'(1);
                    if (minutes == MIN_MAX) overflow <= 1'b1;
                end else begin
                    seconds <= seconds + 6'd1;
                end
            end
        end
    end

`ifdef LAP_CAPTURE_EN
    logic [MIN_W+5:0] lap_head;

    lap_fifo #(
        .DATA_W (MIN_W + 6),
        .DEPTH  (LAP_DEPTH)
    ) u_lap_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (clear),
        .push    (lap && (state != ST_IDLE) && !clear),
        .pop     (lap_rd && !clear),
        .wr_data ({minutes, seconds}),
        .rd_data (lap_head),
        .valid   (lap_valid),
        .full    (lap_full),
        .count   (lap_count)
    );

    assign lap_minutes = lap_head[MIN_W+5:6];
    assign lap_seconds = lap_head[5:0];
`else
    logic unused_lap_inputs;
    assign unused_lap_inputs = lap ^ lap_rd;

    assign lap_minutes = '0;
    assign lap_seconds = '0;
    assign lap_valid   = 1'b0;
    assign lap_full    = 1'b0;
    assign lap_count   = '0;
`endif

endmodule
